// File: rtl/credit_switch_allocator.sv
// credit_switch_allocator
//   Two-stage separable switch allocator for a virtual-channel router with
//   credit-based flow control toward the downstream routers.
//   Stage 1 picks one eligible VC per input port (round-robin over VCs).
//   Stage 2 picks one input port per output port (round-robin over inputs).
//   Grants are combinational (zero-cycle); credit counters, round-robin
//   pointers and optional packet locks are registered.
//
// Optional feature macro: SA_PACKET_LOCK_EN
//   When defined, a granted non-tail flit locks its output port to the
//   winning (input, vc) until that owner is granted with tail_i=1.
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active low
//   switch_request_i    [in][vc]       VC has a flit requesting the switch
//   out_port_i          [in][vc]       requested output port
//   downstream_vc_i     [in][vc]       allocated VC at the downstream router
//   tail_i              [in][vc]       head-of-VC flit is a tail flit
//   credit_return_i     [out][dvc]     one slot freed downstream (pulse)
//   valid_sel_o / vc_sel_o             input port granted / winning VC
//   valid_flit_o / input_vc_sel_o      output port busy / crossbar source
module credit_switch_allocator #(
    parameter int PORT_NUM     = 5,
    parameter int VC_NUM       = 4,
    parameter int CREDIT_DEPTH = 4,
    localparam int PORT_SIZE   = $clog2(PORT_NUM),
    localparam int VC_SIZE     = $clog2(VC_NUM),
    localparam int CNT_SIZE    = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                 switch_request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0]  out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]    downstream_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                 tail_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                 credit_return_i,
    output logic [PORT_NUM-1:0]                             valid_sel_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]                vc_sel_o,
    output logic [PORT_NUM-1:0]                             valid_flit_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]              input_vc_sel_o
);

    // Out-of-range port numbers must never grant, so compare one bit wider.
    localparam logic [PORT_SIZE:0]  PORT_LIMIT = (PORT_SIZE+1)'(PORT_NUM);
    localparam logic [CNT_SIZE-1:0] CNT_FULL   = CNT_SIZE'(CREDIT_DEPTH);

    logic [CNT_SIZE-1:0]  credit_q   [PORT_NUM][VC_NUM];
    logic [CNT_SIZE-1:0]  credit_d   [PORT_NUM][VC_NUM];
    logic [VC_SIZE-1:0]   vc_ptr_q   [PORT_NUM];
    logic [VC_SIZE-1:0]   vc_ptr_d   [PORT_NUM];
    logic [PORT_SIZE-1:0] port_ptr_q [PORT_NUM];
    logic [PORT_SIZE-1:0] port_ptr_d [PORT_NUM];

`ifdef SA_PACKET_LOCK_EN
    logic [PORT_NUM-1:0]  lock_vld_q;
    logic [PORT_NUM-1:0]  lock_vld_d;
    logic [PORT_SIZE-1:0] lock_in_q [PORT_NUM];
    logic [PORT_SIZE-1:0] lock_in_d [PORT_NUM];
    logic [VC_SIZE-1:0]   lock_vc_q [PORT_NUM];
    logic [VC_SIZE-1:0]   lock_vc_d [PORT_NUM];
`else
    // Tail information only matters for packet locking.
    logic unused_tail_s;
    assign unused_tail_s = ^tail_i;
`endif

    logic [PORT_NUM-1:0][VC_NUM-1:0] elig_s;
    logic [PORT_NUM-1:0]  s1_vld_s;
    logic [VC_SIZE-1:0]   s1_vc_s  [PORT_NUM];
    logic [PORT_SIZE-1:0] s1_out_s [PORT_NUM];
    logic [PORT_NUM-1:0]  s2_vld_s;
    logic [PORT_SIZE-1:0] s2_in_s  [PORT_NUM];
    logic [PORT_NUM-1:0]  in_gnt_s;
    logic [VC_SIZE-1:0]   gnt_dvc_s [PORT_NUM];

    // Request eligibility: valid port, downstream credit, and (with locking) not blocked.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (switch_request_i[i][v] && ({1'b0, out_port_i[i][v]} < PORT_LIMIT)) begin
                    elig_s[i][v] = (credit_q[out_port_i[i][v]][downstream_vc_i[i][v]] != '0);
`ifdef SA_PACKET_LOCK_EN
                    if (lock_vld_q[out_port_i[i][v]] &&
                        ((lock_in_q[out_port_i[i][v]] != PORT_SIZE'(i)) ||
                         (lock_vc_q[out_port_i[i][v]] != VC_SIZE'(v)))) begin
                        elig_s[i][v] = 1'b0;
                    end else begin
                        elig_s[i][v] = elig_s[i][v];
                    end
`endif
                end else begin
                    elig_s[i][v] = 1'b0;
                end
            end
        end
    end

    // Stage 1: round-robin VC selection per input port starting at its pointer.
    always_comb begin
        int idx;
        idx = 0;
        for (int i = 0; i < PORT_NUM; i++) begin
            s1_vld_s[i] = 1'b0;
            s1_vc_s[i]  = '0;
            s1_out_s[i] = '0;
            for (int off = 0; off < VC_NUM; off++) begin
                idx = int'(vc_ptr_q[i]) + off;
                idx = (idx >= VC_NUM) ? (idx - VC_NUM) : idx;
                if (!s1_vld_s[i] && elig_s[i][idx]) begin
                    s1_vld_s[i] = 1'b1;
                    s1_vc_s[i]  = VC_SIZE'(idx);
                    s1_out_s[i] = out_port_i[i][idx];
                end else begin
                    s1_vld_s[i] = s1_vld_s[i];
                end
            end
        end
    end

    // Stage 2: round-robin input selection per output port starting at its pointer.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < PORT_NUM; o++) begin
            s2_vld_s[o] = 1'b0;
            s2_in_s[o]  = '0;
            for (int off = 0; off < PORT_NUM; off++) begin
                idx = int'(port_ptr_q[o]) + off;
                idx = (idx >= PORT_NUM) ? (idx - PORT_NUM) : idx;
                if (!s2_vld_s[o] && s1_vld_s[idx] && (s1_out_s[idx] == PORT_SIZE'(o))
`ifdef SA_PACKET_LOCK_EN
                    && (!lock_vld_q[o] || (lock_in_q[o] == PORT_SIZE'(idx)))
`endif
                   ) begin
                    s2_vld_s[o] = 1'b1;
                    s2_in_s[o]  = PORT_SIZE'(idx);
                end else begin
                    s2_vld_s[o] = s2_vld_s[o];
                end
            end
        end
    end

    // Final grants and outputs; everything forced low while reset is asserted.
    always_comb begin
        in_gnt_s       = '0;
        valid_sel_o    = '0;
        vc_sel_o       = '0;
        valid_flit_o   = '0;
        input_vc_sel_o = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            gnt_dvc_s[o] = '0;
            if (s2_vld_s[o]) begin
                in_gnt_s[s2_in_s[o]] = 1'b1;
                gnt_dvc_s[o] = downstream_vc_i[s2_in_s[o]][s1_vc_s[s2_in_s[o]]];
            end else begin
                gnt_dvc_s[o] = '0;
            end
        end
        if (rst) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                valid_sel_o[p]    = in_gnt_s[p];
                vc_sel_o[p]       = in_gnt_s[p] ? s1_vc_s[p] : '0;
                valid_flit_o[p]   = s2_vld_s[p];
                input_vc_sel_o[p] = s2_vld_s[p] ? s2_in_s[p] : '0;
            end
        end else begin
            valid_sel_o = '0;
        end
    end

    // Next state: credit accounting, pointer advance and lock tracking.
    always_comb begin
        logic dec;
        dec = 1'b0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int d = 0; d < VC_NUM; d++) begin
                dec = s2_vld_s[o] && (gnt_dvc_s[o] == VC_SIZE'(d));
                case ({dec, credit_return_i[o][d]})
                    2'b10:   credit_d[o][d] = credit_q[o][d] - CNT_SIZE'(1);
                    // A return into a full counter saturates rather than wrapping.
                    2'b01:   credit_d[o][d] = (credit_q[o][d] == CNT_FULL) ?
                                              credit_q[o][d] : (credit_q[o][d] + CNT_SIZE'(1));
                    default: credit_d[o][d] = credit_q[o][d];
                endcase
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            if (in_gnt_s[i]) begin
                vc_ptr_d[i] = (s1_vc_s[i] == VC_SIZE'(VC_NUM - 1)) ? '0 : (s1_vc_s[i] + VC_SIZE'(1));
            end else begin
                vc_ptr_d[i] = vc_ptr_q[i];
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            if (s2_vld_s[o]) begin
                port_ptr_d[o] = (s2_in_s[o] == PORT_SIZE'(PORT_NUM - 1)) ? '0 : (s2_in_s[o] + PORT_SIZE'(1));
            end else begin
                port_ptr_d[o] = port_ptr_q[o];
            end
        end
`ifdef SA_PACKET_LOCK_EN
        lock_vld_d = lock_vld_q;
        lock_in_d  = lock_in_q;
        lock_vc_d  = lock_vc_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (s2_vld_s[o]) begin
                // Single-flit packets (tail on first grant) never lock.
                lock_vld_d[o] = !tail_i[s2_in_s[o]][s1_vc_s[s2_in_s[o]]];
                lock_in_d[o]  = s2_in_s[o];
                lock_vc_d[o]  = s1_vc_s[s2_in_s[o]];
            end else begin
                lock_vld_d[o] = lock_vld_q[o];
            end
        end
`endif
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int d = 0; d < VC_NUM; d++) begin
                    credit_q[o][d] <= CNT_FULL;
                end
                vc_ptr_q[o]   <= '0;
                port_ptr_q[o] <= '0;
`ifdef SA_PACKET_LOCK_EN
                lock_in_q[o]  <= '0;
                lock_vc_q[o]  <= '0;
`endif
            end
`ifdef SA_PACKET_LOCK_EN
            lock_vld_q <= '0;
`endif
        end else begin
            credit_q   <= credit_d;
            vc_ptr_q   <= vc_ptr_d;
            port_ptr_q <= port_ptr_d;
`ifdef SA_PACKET_LOCK_EN
            lock_vld_q <= lock_vld_d;
            lock_in_q  <= lock_in_d;
            lock_vc_q  <= lock_vc_d;
`endif
        end
    end

endmodule
